scope_trigger_detector: RTL

- Edge/level trigger generator directly upstream of the scope trigger hub.
- Taps the sample stream feeding the capture buffer and watches one selected channel for a hysteresis-qualified threshold crossing.
- Emits a single-cycle trigger pulse, which drives the hub's trigger_in.
- Handles holdoff, single/normal/auto acquisition modes and re-arming. Re-arming is paced by the hub's capture_inhibit handshake.

---
 rtl/scope_trigger_detector.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/scope_trigger_detector.sv
// rtl/scope_trigger_detector.sv - hysteresis-qualified edge trigger with holdoff, auto and single-shot acquisition
module scope_trigger_detector #(
  parameter int DATA_WIDTH = 16,
  parameter int DEST_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in_tdata,
  input  logic [DEST_WIDTH-1:0] data_in_tdest,
  input  logic                  data_in_tvalid,
  input  logic [DEST_WIDTH-1:0] trigger_channel,
  input  logic [DATA_WIDTH-1:0] trigger_level,
  input  logic [DATA_WIDTH-1:0] hysteresis,
  input  logic [1:0]            trigger_mode,
  input  logic [1:0]            acquisition_mode,
  input  logic                  arm,
  input  logic                  disarm,
  input  logic [31:0]           holdoff,
  input  logic [31:0]           auto_timeout,
  input  logic                  capture_inhibit,
  output logic                  trigger_out,
  output logic                  trigger_forced,
  output logic [1:0]            trigger_state
);

  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLDOFF = 2'd1, ARMED = 2'd2, FIRED = 2'd3} state_t;
  typedef enum logic [1:0] {REG_UNKNOWN = 2'd0, REG_LOW = 2'd1, REG_HIGH = 2'd2} region_t;

  state_t  state, state_d;
  region_t region;
  logic [31:0] hold_cnt, hold_d;
  logic [31:0] to_cnt, to_d;
  logic        phase, phase_d;
  logic        fire, forced_d;

  logic signed [EW-1:0] sample_ext, level_ext, hyst_ext, lower;
  logic [DEST_WIDTH-1:0] channel_q;
  logic qualified, channel_changed, above, below;
  logic rise_evt, fall_evt, edge_event;
  logic single_mode, auto_mode, timeout_hit;

  // Two guard bits make level - hysteresis exact for every input combination.
  assign sample_ext = {{2{data_in_tdata[DATA_WIDTH-1]}}, data_in_tdata};
  assign level_ext  = {{2{trigger_level[DATA_WIDTH-1]}}, trigger_level};
  assign hyst_ext   = {2'b00, hysteresis};
  assign lower      = level_ext - hyst_ext;

  assign qualified       = data_in_tvalid && (data_in_tdest == trigger_channel);
  assign channel_changed = (channel_q != trigger_channel);
  assign above           = (sample_ext >= level_ext);
  assign below           = (sample_ext < lower);

  // A sample judged against the previous channel's region would be meaningless.
  assign rise_evt = qualified && !channel_changed && (region == REG_LOW)  && above;
  assign fall_evt = qualified && !channel_changed && (region == REG_HIGH) && below;

  always_comb begin
    edge_event = 1'b0;
    case (trigger_mode)
      2'd0:    edge_event = rise_evt;
      2'd1:    edge_event = fall_evt;
      2'd2:    edge_event = rise_evt || fall_evt;
      default: edge_event = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      region    <= REG_UNKNOWN;
      channel_q <= '0;
    end else begin
      channel_q <= trigger_channel;
      if (channel_changed) begin
        region <= REG_UNKNOWN;
      end else if (qualified) begin
        if (above) begin
          region <= REG_HIGH;
        end else if (below) begin
          region <= REG_LOW;
        end
      end
    end
  end

  assign single_mode = (acquisition_mode == 2'd1);
  assign auto_mode   = (acquisition_mode == 2'd2);
  assign timeout_hit = auto_mode && (auto_timeout != 32'd0) && (to_cnt == auto_timeout - 32'd1);

  always_comb begin
    state_d  = state;
    hold_d   = hold_cnt;
    to_d     = to_cnt;
    phase_d  = phase;
    fire     = 1'b0;
    forced_d = trigger_forced;
    if (disarm) begin
      state_d = IDLE;
      phase_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            if (holdoff == 32'd0) begin
              state_d = ARMED;
              to_d    = 32'd0;
            end else begin
              state_d = HOLDOFF;
              hold_d  = holdoff;
            end
          end
        end
        HOLDOFF: begin
          if (hold_cnt <= 32'd1) begin
            state_d = ARMED;
            to_d    = 32'd0;
          end else begin
            hold_d = hold_cnt - 32'd1;
          end
        end
        ARMED: begin
          to_d = to_cnt + 32'd1;
          if (edge_event && !capture_inhibit) begin
            fire     = 1'b1;
            forced_d = 1'b0;
            state_d  = FIRED;
            phase_d  = 1'b0;
          end else if (timeout_hit) begin
            fire     = 1'b1;
            forced_d = 1'b1;
            state_d  = FIRED;
            phase_d  = 1'b0;
          end
        end
        FIRED: begin
          // Phase 0 waits for the hub to raise capture_inhibit, phase 1 for it to drop.
          if (!phase) begin
            if (capture_inhibit) phase_d = 1'b1;
          end else if (!capture_inhibit) begin
            phase_d = 1'b0;
            if (single_mode) begin
              state_d = IDLE;
            end else if (holdoff == 32'd0) begin
              state_d = ARMED;
              to_d    = 32'd0;
            end else begin
              state_d = HOLDOFF;
              hold_d  = holdoff;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      hold_cnt       <= 32'd0;
      to_cnt         <= 32'd0;
      phase          <= 1'b0;
      trigger_out    <= 1'b0;
      trigger_forced <= 1'b0;
    end else begin
      state          <= state_d;
      hold_cnt       <= hold_d;
      to_cnt         <= to_d;
      phase          <= phase_d;
      trigger_out    <= fire;
      trigger_forced <= forced_d;
    end
  end

  assign trigger_state = state;

endmodule
